// File: rtl/pipe_pkg.sv
// Shared constants for the pipe_stage slice chain.
// Also provides the width function for the occupancy port.
package pipe_pkg;

  localparam int PIPE_MAX_DEPTH = 4;

  // Each slice holds at most two entries (main + skid), so 2*depth+1 states.
  function automatic int occ_width(input int depth);
    return $clog2(2 * depth + 1);
  endfunction

endpackage

// File: rtl/pipe_slice.sv
// One register slice: a valid/data main register, plus one skid entry when
// PIPE_SKID_EN is defined so that the upstream ready comes straight from a flop.
module pipe_slice import pipe_pkg::*; #(
  parameter int               WIDTH  = 32,
  parameter logic [WIDTH-1:0] BUBBLE = '0
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             stall_i,
  input  logic             up_valid_i,
  input  logic [WIDTH-1:0] up_data_i,
  output logic             up_ready_o,
  output logic             dn_valid_o,
  output logic [WIDTH-1:0] dn_data_o,
  input  logic             dn_ready_i,
  output logic [1:0]       occ_o
);

  logic             main_vld_q, main_vld_d;
  logic [WIDTH-1:0] main_dat_q, main_dat_d;

  assign dn_valid_o = main_vld_q;
  assign dn_data_o  = main_dat_q;

`ifdef PIPE_SKID_EN
  logic             skid_vld_q, skid_vld_d;
  logic [WIDTH-1:0] skid_dat_q, skid_dat_d;
  logic             main_free, acc;

  assign up_ready_o = !stall_i && !skid_vld_q;
  assign main_free  = !stall_i && (!main_vld_q || dn_ready_i);
  assign acc        = up_valid_i && up_ready_o;
  assign occ_o      = {1'b0, main_vld_q} + {1'b0, skid_vld_q};

  // The skid is always older than anything arriving, so it drains first.
  always_comb begin
    main_vld_d = main_vld_q;
    main_dat_d = main_dat_q;
    skid_vld_d = skid_vld_q;
    skid_dat_d = skid_dat_q;
    if (main_free) begin
      if (skid_vld_q) begin
        main_vld_d = 1'b1;
        main_dat_d = skid_dat_q;
        skid_vld_d = 1'b0;
        skid_dat_d = BUBBLE;
      end else begin
        main_vld_d = acc;
        main_dat_d = acc ? up_data_i : BUBBLE;
      end
    end else if (acc) begin
      skid_vld_d = 1'b1;
      skid_dat_d = up_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      main_vld_q <= 1'b0;
      main_dat_q <= BUBBLE;
      skid_vld_q <= 1'b0;
      skid_dat_q <= BUBBLE;
    end else begin
      main_vld_q <= main_vld_d;
      main_dat_q <= main_dat_d;
      skid_vld_q <= skid_vld_d;
      skid_dat_q <= skid_dat_d;
    end
  end
`else
  assign up_ready_o = !stall_i && (!main_vld_q || dn_ready_i);
  assign occ_o      = {1'b0, main_vld_q};

  // Emptied slices reload BUBBLE so an invalid output never shows stale data.
  always_comb begin
    main_vld_d = main_vld_q;
    main_dat_d = main_dat_q;
    if (up_ready_o) begin
      main_vld_d = up_valid_i;
      main_dat_d = up_valid_i ? up_data_i : BUBBLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      main_vld_q <= 1'b0;
      main_dat_q <= BUBBLE;
    end else begin
      main_vld_q <= main_vld_d;
      main_dat_q <= main_dat_d;
    end
  end
`endif

endmodule

// File: rtl/pipe_stage.sv
// Valid/ready pipeline of DEPTH chained pipe_slice registers with flush/stall.
// Define PIPE_SKID_EN to give every slice a skid entry and registered ready.
module pipe_stage import pipe_pkg::*; #(
  parameter int               WIDTH  = 32,
  parameter int               DEPTH  = 1,
  parameter logic [WIDTH-1:0] BUBBLE = '0
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  input  logic                         flush,
  input  logic                         stall,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [occ_width(DEPTH)-1:0]  occupancy
);

  localparam int OCC_W = occ_width(DEPTH);

  if (DEPTH < 1 || DEPTH > PIPE_MAX_DEPTH) begin : g_bad_depth
    $error("pipe_stage: DEPTH out of range");
  end
  if (WIDTH < 1 || WIDTH > 256) begin : g_bad_width
    $error("pipe_stage: WIDTH out of range");
  end

  logic [DEPTH:0]            vld_chain, rdy_chain;
  logic [DEPTH:0][WIDTH-1:0] dat_chain;
  logic [DEPTH-1:0][1:0]     slice_occ;
  logic                      clr;
  logic [OCC_W-1:0]          occ_sum;

  // Reset and flush share the clear path; either wins over stall and input.
  assign clr              = RST || flush;
  assign vld_chain[0]     = in_valid;
  assign dat_chain[0]     = in_data;
  assign rdy_chain[DEPTH] = out_ready && !stall;
  assign in_ready         = rdy_chain[0] && !flush && !RST;
  assign out_valid        = vld_chain[DEPTH];
  assign out_data         = dat_chain[DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_slice
    pipe_slice #(.WIDTH(WIDTH), .BUBBLE(BUBBLE)) u_slice (
      .clk_i      (CLK),
      .clr_i      (clr),
      .stall_i    (stall),
      .up_valid_i (vld_chain[k]),
      .up_data_i  (dat_chain[k]),
      .up_ready_o (rdy_chain[k]),
      .dn_valid_o (vld_chain[k+1]),
      .dn_data_o  (dat_chain[k+1]),
      .dn_ready_i (rdy_chain[k+1]),
      .occ_o      (slice_occ[k])
    );
  end

  always_comb begin
    occ_sum = '0;
    for (int k = 0; k < DEPTH; k++) occ_sum = occ_sum + OCC_W'(slice_occ[k]);
  end

  assign occupancy = occ_sum;

endmodule

// File: tb/tb_pipe_stage.sv
// Scoreboard bench for pipe_stage (DEPTH=3, WIDTH=8, non-zero BUBBLE).
// Honours PIPE_SKID_EN for capacity and ready expectations.
module tb_pipe_stage;
  import pipe_pkg::*;

  localparam int W = 8;
  localparam int D = 3;
  localparam logic [W-1:0] BUB = 8'hEE;
`ifdef PIPE_SKID_EN
  localparam int CAP = 2 * D;
`else
  localparam int CAP = D;
`endif
  localparam int OW = occ_width(D);

  logic CLK = 1'b0;
  logic RST, in_valid, in_ready, flush, stall, out_valid, out_ready;
  logic [W-1:0] in_data, out_data;
  logic [OW-1:0] occupancy;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] sb[$];

  pipe_stage #(.WIDTH(W), .DEPTH(D), .BUBBLE(BUB)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .flush(flush), .stall(stall), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .occupancy(occupancy)
  );

  always #5 CLK = ~CLK;

  // Scoreboard: push on accepted input, pop and compare on counted output.
  always @(negedge CLK) begin
    if (!RST) begin
      if (out_valid && out_ready && !stall) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL sb_underflow: got data %h want no transfer", out_data);
        end else begin
          logic [W-1:0] exp;
          exp = sb.pop_front();
          if (out_data !== exp) begin errors++; $display("FAIL sb_data: got %h want %h", out_data, exp); end
        end
      end
      if (!out_valid) begin
        checks++;
        if (out_data !== BUB) begin errors++; $display("FAIL idle_bubble: got %h want %h", out_data, BUB); end
      end
    end
    if (RST || flush) sb.delete();
    else if (in_valid && in_ready) sb.push_back(in_data);
  end

  task automatic tick(); @(posedge CLK); #1; endtask
  task automatic settle(); #1; endtask

  task automatic fill(input logic [W-1:0] base, output int n);
    n = 0; out_ready = 0; stall = 0; flush = 0;
    for (int c = 0; c < 4 * CAP + 4; c++) begin
      tick(); in_valid = 1; in_data = base + W'(n); settle();
      if (in_ready) n++; else break;
    end
    tick(); in_valid = 0;
  endtask

  task automatic drain();
    out_ready = 1; in_valid = 0; stall = 0; flush = 0;
    for (int c = 0; c < 4 * CAP + 4; c++) begin
      tick(); settle();
      if (occupancy == 0) break;
    end
  endtask

  task automatic test_reset();
    RST = 1; in_valid = 1; in_data = 8'h55; flush = 0; stall = 0; out_ready = 1;
    tick(); tick(); settle();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    checks++; if (occupancy !== '0) begin errors++; $display("FAIL rst_occ: got %0d want 0", occupancy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== BUB) begin errors++; $display("FAIL rst_out_data: got %h want %h", out_data, BUB); end
    tick(); RST = 0; in_valid = 0; settle();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_stream();
    logic ev; logic [W-1:0] ed;
    out_ready = 1;
    for (int i = 0; i < 8 + D + 1; i++) begin
      tick(); in_valid = (i < 8); in_data = W'(i + 1); settle();
      ev = (i >= D && i < D + 8);
      ed = ev ? W'(i - D + 1) : BUB;
      if (i < 8) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d]: got %b want 1", i, in_ready); end
      end
      checks++; if (out_valid !== ev) begin errors++; $display("FAIL stream_valid[%0d]: got %b want %b", i, out_valid, ev); end
      checks++; if (out_data !== ed) begin errors++; $display("FAIL stream_data[%0d]: got %h want %h", i, out_data, ed); end
    end
    tick(); in_valid = 0;
  endtask

  task automatic test_backpressure();
    int n;
    fill(8'h01, n); settle();
    checks++; if (n != CAP) begin errors++; $display("FAIL bp_accepts: got %0d want %0d", n, CAP); end
    checks++; if (occupancy !== OW'(CAP)) begin errors++; $display("FAIL bp_occ: got %0d want %0d", occupancy, CAP); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
    for (int i = 0; i < 3; i++) begin
      tick(); settle();
      checks++; if (out_valid !== 1'b1 || out_data !== 8'h01) begin
        errors++; $display("FAIL bp_hold[%0d]: got v=%b d=%h want v=1 d=01", i, out_valid, out_data);
      end
    end
    drain();
    checks++; if (occupancy !== '0 || sb.size() != 0) begin
      errors++; $display("FAIL bp_drain: got occ=%0d pending=%0d want 0/0", occupancy, sb.size());
    end
  endtask

  task automatic test_flush();
    int n;
    fill(8'h20, n);
    tick(); flush = 1; in_valid = 1; in_data = 8'hAA; settle();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
    tick(); flush = 0; in_valid = 0; out_ready = 1; settle();
    checks++; if (occupancy !== '0) begin errors++; $display("FAIL flush_occ: got %0d want 0", occupancy); end
    checks++; if (out_valid !== 1'b0 || out_data !== BUB) begin
      errors++; $display("FAIL flush_out: got v=%b d=%h want v=0 d=%h", out_valid, out_data, BUB);
    end
    for (int i = 0; i < 4; i++) begin
      tick(); settle();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_leak[%0d]: got v=%b d=%h want v=0", i, out_valid, out_data); end
    end
  endtask

  task automatic test_stall();
    int n;
    fill(8'h40, n);
    tick(); stall = 1; out_ready = 1; in_valid = 1; in_data = 8'h77; settle();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b want 0", in_ready); end
    for (int i = 0; i < 4; i++) begin
      tick(); settle();
      checks++; if (out_valid !== 1'b1 || out_data !== 8'h40 || occupancy !== OW'(CAP)) begin
        errors++; $display("FAIL stall_freeze[%0d]: got v=%b d=%h occ=%0d want v=1 d=40 occ=%0d", i, out_valid, out_data, occupancy, CAP);
      end
    end
    tick(); stall = 0; in_valid = 0;
    drain();
    checks++; if (occupancy !== '0 || sb.size() != 0) begin
      errors++; $display("FAIL stall_drain: got occ=%0d pending=%0d want 0/0", occupancy, sb.size());
    end
  endtask

`ifndef PIPE_SKID_EN
  task automatic test_full_throughput();
    int n;
    fill(8'h60, n);
    for (int i = 0; i < 4; i++) begin
      tick(); in_valid = 1; in_data = W'(8'h70 + i); out_ready = 1; settle();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_in_ready[%0d]: got %b want 1", i, in_ready); end
      checks++; if (occupancy !== OW'(D)) begin errors++; $display("FAIL full_occ[%0d]: got %0d want %0d", i, occupancy, D); end
    end
    tick(); in_valid = 0;
    drain();
  endtask
`endif

  task automatic test_rst_mid();
    out_ready = 0;
    tick(); in_valid = 1; in_data = 8'h31; settle();
    tick(); in_data = 8'h32; settle();
    tick(); in_valid = 0; settle();
    checks++; if (occupancy !== OW'(2)) begin errors++; $display("FAIL rmid_occ: got %0d want 2", occupancy); end
    tick(); RST = 1; settle();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rmid_in_ready_rst: got %b want 0", in_ready); end
    tick(); RST = 0; settle();
    checks++; if (occupancy !== '0 || out_valid !== 1'b0 || out_data !== BUB) begin
      errors++; $display("FAIL rmid_clear: got occ=%0d v=%b d=%h want 0/0/%h", occupancy, out_valid, out_data, BUB);
    end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready_after: got %b want 1", in_ready); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      tick();
      in_valid = 1'($urandom_range(0, 1)); in_data = W'($urandom);
      out_ready = ($urandom_range(0, 3) != 0); stall = ($urandom_range(0, 15) == 0);
      settle();
      checks++; if (int'(occupancy) != sb.size() || int'(occupancy) > CAP) begin
        errors++; $display("FAIL rand_occ[%0d]: got %0d want %0d (cap %0d)", i, occupancy, sb.size(), CAP);
      end
    end
    drain();
    checks++; if (occupancy !== '0 || sb.size() != 0) begin
      errors++; $display("FAIL rand_drain: got occ=%0d pending=%0d want 0/0", occupancy, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_stall();
`ifndef PIPE_SKID_EN
    test_full_throughput();
`endif
    test_rst_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pipe_stage.md
PIPE_STAGE -- requirements
Module: pipe_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 32, payload width in bits (1..256).
REQ-002 SHALL have parameter DEPTH, default 1, number of chained register slices (1..PIPE_MAX_DEPTH).
REQ-003 SHALL have parameter BUBBLE, default all-zero WIDTH-bit value, payload loaded on reset/flush (NOP encoding).
REQ-004 SHALL have port CLK  input  1  single rising-edge clock.
REQ-005 SHALL have port RST  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  upstream payload valid.
REQ-007 SHALL have port in_ready  output  1  stage can accept this cycle.
REQ-008 SHALL have port in_data  input  WIDTH  upstream payload.
REQ-009 SHALL have port flush  input  1  discard all held and incoming payloads.
REQ-010 SHALL have port stall  input  1  freeze every slice regardless of out_ready (legacy EN=0).
REQ-011 SHALL have port out_valid  output  1  last slice holds valid payload.
REQ-012 SHALL have port out_ready  input  1  downstream accepts.
REQ-013 SHALL have port out_data  output  WIDTH  last slice payload; BUBBLE when out_valid=0.
REQ-014 SHALL have port occupancy  output  $clog2(2*DEPTH+1)  count of valid entries held.

Function
REQ-015 Transfer SHALL occur only on a cycle with valid and ready both high on the same side.
REQ-016 in_ready SHALL equal !stall && !flush && (slice0 empty || slice0 advancing) without PIPE_SKID_EN.
REQ-017 Slice k SHALL advance when valid and (slice k+1 empty or advancing); last slice advances on out_ready && !stall.
REQ-018 Empty slices SHALL be filled by upstream slices (bubble collapse); no valid entry is ever overwritten or duplicated.
REQ-019 Latency SHALL be DEPTH cycles from in_valid&&in_ready to out_valid with out_ready held high; throughput 1 per cycle.
REQ-020 While out_valid && !out_ready, out_data SHALL remain stable.
REQ-021 flush SHALL clear all valid bits and load BUBBLE into every slice at the next edge; flush has priority over stall and over any same-cycle input.
REQ-022 stall SHALL hold all slices unchanged; out_valid may stay high but no output transfer is counted while stall=1.
REQ-023 occupancy SHALL equal the number of valid slice (and skid) entries after each edge; never exceeds 2*DEPTH.
REQ-024 Simultaneous input accept and output transfer with full pipe SHALL keep occupancy unchanged.

Reset
REQ-025 On RST=1 at an edge all valid bits SHALL clear, all data SHALL load BUBBLE, occupancy=0, out_valid=0, out_data=BUBBLE.
REQ-026 in_ready SHALL be 0 during the RST cycle and 1 on the first cycle after (stall=0, flush=0).
REQ-027 RST mid-transfer SHALL discard all entries identically to flush; RST has priority over flush and stall.

Configuration
REQ-028 Macro PIPE_SKID_EN, when defined, SHALL add one skid register per slice so every in_ready/out_ready path is registered; in_ready = !stall && !flush && !skid0_full, registered from the previous edge.
REQ-029 With PIPE_SKID_EN, each slice SHALL absorb one extra entry when downstream deasserts ready, and drain the skid before the main register accepts new data, preserving order.
REQ-030 Without PIPE_SKID_EN, no skid storage SHALL exist; occupancy never exceeds DEPTH.

Structure
REQ-031 Shared package pipe_pkg SHALL hold PIPE_MAX_DEPTH=4 and the occupancy width function.
REQ-032 One sub-module pipe_slice (single valid/data register with optional skid) SHALL be instantiated DEPTH times by generate.

Verification
REQ-033 DEPTH=2, out_ready=1, stream 0x1..0x8 back-to-back -> out_data 0x1..0x8 starting 2 cycles later, one per cycle.
REQ-034 DEPTH=3, out_ready=0 after 3 accepts -> in_ready=0 (no skid), occupancy=3, out_data=0x1 stable until out_ready=1.
REQ-035 Full pipe, flush pulse with in_valid=1,in_data=0xAA -> next cycle occupancy=0, out_valid=0, out_data=BUBBLE, 0xAA never emitted.
REQ-036 stall=1 for 4 cycles with out_ready=1 -> no transfers, data frozen; resume yields original order.
REQ-037 PIPE_SKID_EN, DEPTH=1, out_ready dropped mid-stream -> 2 entries held, no loss, in_ready drops one cycle late.
REQ-038 RST asserted with occupancy=2 -> next cycle occupancy=0, out_valid=0, in_ready=0 then 1.
